gpio_in_debounce: RTL and testbench

- Input conditioning stage between the board switches/buttons and the processor datapath's 8-bit GPIO_i input.
- Synchronises each raw pin to clk with a two-flop synchroniser.
- Filters contact bounce by requiring a new level to hold for a programmable number of cycles before it is accepted.
- Presents the clean levels to the datapath, with per-bit edge pulses and a sticky "input changed" flag for polling software.

---
 rtl/gpio_in_debounce.sv | 112 +++++++++++
 tb/tb_gpio_in_debounce.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_debounce.sv
// ============================================================================
// gpio_in_debounce: two-flop synchroniser plus per-bit counter debounce for
// switch/button inputs, with edge pulses and a sticky change flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpio_in_debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_WIDTH     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             change_o,
  output logic             event_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] db_q;
  logic [WIDTH-1:0] db_d;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             change_q;
  logic             change_d;
  logic             event_q;
  logic             event_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

  // Each pin counts consecutive mismatches independently; any agreement
  // with the accepted level restarts the count.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 mismatch;
    logic                 done;

    assign mismatch  = s2_q[i] ^ db_q[i];
    assign done      = mismatch && (cnt_q == CNT_LAST);
    assign accept[i] = done;

    always_comb begin
      cnt_d = cnt_q + CNT_ONE;
      if (!mismatch || done) begin
        cnt_d = '0;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  always_comb begin
    db_d     = db_q ^ accept;
    rise_d   = accept & s2_q;
    fall_d   = accept & ~s2_q;
    change_d = |accept;
    // Set has priority over a simultaneous clear so no change is lost.
    event_d  = change_q | (event_q & ~clr_i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      change_q <= 1'b0;
      event_q  <= 1'b0;
    end else begin
      db_q     <= db_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      change_q <= change_d;
      event_q  <= event_d;
    end
  end

  assign data_o   = db_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
  assign change_o = change_q;
  assign event_o  = event_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_in_debounce.sv
// ============================================================================
// tb_gpio_in_debounce: directed checks of gpio_in_debounce with STABLE_CYCLES
// of 4 (main instance) and 1 (pure-synchroniser instance).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gpio_in_debounce;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] raw_i = 8'h00;
  logic       clr_i = 1'b0;

  logic [7:0] data_o, rise_o, fall_o;
  logic       change_o, event_o;
  logic [7:0] data1_o, rise1_o, fall1_o;
  logic       change1_o, event1_o;

  int checks = 0;
  int errors = 0;

  gpio_in_debounce #(.WIDTH(8), .STABLE_CYCLES(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .raw_i(raw_i), .clr_i(clr_i),
    .data_o(data_o), .rise_o(rise_o), .fall_o(fall_o),
    .change_o(change_o), .event_o(event_o)
  );

  gpio_in_debounce #(.WIDTH(8), .STABLE_CYCLES(1), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .raw_i(raw_i), .clr_i(clr_i),
    .data_o(data1_o), .rise_o(rise1_o), .fall_o(fall1_o),
    .change_o(change1_o), .event_o(event1_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [7:0] v);
    raw_i = v;
    repeat (10) tick();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #2;
    checks++;
    if ({data_o, rise_o, fall_o, change_o, event_o} !== 26'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {data_o, rise_o, fall_o, change_o, event_o});
    end
    checks++;
    if ({data1_o, rise1_o, fall1_o, change1_o, event1_o} !== 26'h0) begin
      errors++;
      $display("FAIL reset_outputs_s1: got %h expected 0", {data1_o, rise1_o, fall1_o, change1_o, event1_o});
    end
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (data_o !== 8'h00 || event_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: data %h event %b expected 00 0", data_o, event_o);
    end
  endtask

  task automatic test_latency();
    raw_i = 8'h01;
    repeat (5) tick();
    checks++;
    if (data_o !== 8'h00) begin
      errors++;
      $display("FAIL latency_edge4: data %h expected 00", data_o);
    end
    tick();
    checks++;
    if (data_o !== 8'h01 || rise_o !== 8'h01 || change_o !== 1'b1 || event_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_edge5: data %h rise %h change %b event %b expected 01 01 1 0",
               data_o, rise_o, change_o, event_o);
    end
    tick();
    checks++;
    if (data_o !== 8'h01 || rise_o !== 8'h00 || change_o !== 1'b0 || event_o !== 1'b1) begin
      errors++;
      $display("FAIL latency_edge6: data %h rise %h change %b event %b expected 01 00 0 1",
               data_o, rise_o, change_o, event_o);
    end
    settle(8'h01);
  endtask

  task automatic test_glitch();
    for (int e = 0; e < 10; e++) begin
      raw_i = (e < 3) ? 8'h09 : 8'h01;
      tick();
      checks++;
      if (data_o !== 8'h01 || rise_o !== 8'h00 || fall_o !== 8'h00 || change_o !== 1'b0) begin
        errors++;
        $display("FAIL glitch_e%0d: data %h rise %h fall %h change %b expected 01 00 00 0",
                 e, data_o, rise_o, fall_o, change_o);
      end
    end
    checks++;
    if (event_o !== 1'b0) begin
      errors++;
      $display("FAIL glitch_event: got %b expected 0", event_o);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] seq [5];
    logic [7:0] exp_rise, exp_data;
    seq = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h01};
    settle(8'h00);
    for (int e = 0; e < 12; e++) begin
      raw_i    = (e < 5) ? seq[e] : 8'h01;
      tick();
      exp_rise = (e == 9) ? 8'h01 : 8'h00;
      exp_data = (e >= 9) ? 8'h01 : 8'h00;
      checks++;
      if (rise_o !== exp_rise || fall_o !== 8'h00 || data_o !== exp_data) begin
        errors++;
        $display("FAIL bounce_e%0d: rise %h fall %h data %h expected %h 00 %h",
                 e, rise_o, fall_o, data_o, exp_rise, exp_data);
      end
    end
  endtask

  task automatic test_multi_fall();
    logic [7:0] exp_fall, exp_data;
    logic       exp_chg, exp_evt;
    settle(8'hFF);
    raw_i = 8'h0F;
    for (int e = 0; e < 8; e++) begin
      tick();
      exp_fall = (e == 5) ? 8'hF0 : 8'h00;
      exp_data = (e >= 5) ? 8'h0F : 8'hFF;
      exp_chg  = (e == 5);
      exp_evt  = (e >= 6);
      checks++;
      if (fall_o !== exp_fall || rise_o !== 8'h00 || data_o !== exp_data ||
          change_o !== exp_chg || event_o !== exp_evt) begin
        errors++;
        $display("FAIL multi_fall_e%0d: fall %h rise %h data %h change %b event %b expected %h 00 %h %b %b",
                 e, fall_o, rise_o, data_o, change_o, event_o, exp_fall, exp_data, exp_chg, exp_evt);
      end
    end
  endtask

  task automatic test_event_clr();
    raw_i = 8'h0E;
    repeat (6) tick();
    checks++;
    if (change_o !== 1'b1 || fall_o !== 8'h01 || event_o !== 1'b1) begin
      errors++;
      $display("FAIL evclr_change: change %b fall %h event %b expected 1 01 1", change_o, fall_o, event_o);
    end
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    checks++;
    if (event_o !== 1'b1) begin
      errors++;
      $display("FAIL evclr_set_wins: event %b expected 1", event_o);
    end
    tick();
    checks++;
    if (event_o !== 1'b1) begin
      errors++;
      $display("FAIL evclr_hold: event %b expected 1", event_o);
    end
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    checks++;
    if (event_o !== 1'b0) begin
      errors++;
      $display("FAIL evclr_clear: event %b expected 0", event_o);
    end
    tick();
    checks++;
    if (event_o !== 1'b0) begin
      errors++;
      $display("FAIL evclr_stays: event %b expected 0", event_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_d, exp_r, exp_d1, exp_r1;
    raw_i = 8'hAA;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    checks++;
    if ({data_o, rise_o, fall_o, change_o, event_o} !== 26'h0 || data1_o !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_async: dut %h dut1_data %h expected 0 00",
               {data_o, rise_o, fall_o, change_o, event_o}, data1_o);
    end
    repeat (2) tick();
    checks++;
    if (data_o !== 8'h00 || data1_o !== 8'h00 || event_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_held: data %h data1 %h event %b expected 00 00 0", data_o, data1_o, event_o);
    end
    reset = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      exp_d  = (e >= 5) ? 8'hAA : 8'h00;
      exp_r  = (e == 5) ? 8'hAA : 8'h00;
      exp_d1 = (e >= 2) ? 8'hAA : 8'h00;
      exp_r1 = (e == 2) ? 8'hAA : 8'h00;
      checks++;
      if (data_o !== exp_d || rise_o !== exp_r || data1_o !== exp_d1 || rise1_o !== exp_r1) begin
        errors++;
        $display("FAIL reset_mid_e%0d: data %h rise %h data1 %h rise1 %h expected %h %h %h %h",
                 e, data_o, rise_o, data1_o, rise1_o, exp_d, exp_r, exp_d1, exp_r1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_bounce();
    test_multi_fall();
    test_event_clr();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
